// File: rtl/adv7393_fetch_sched_pkg.sv
// ---------------------------------------------------------------------------
// adv7393_fetch_sched_pkg
// Shared types, constants and window/address helpers for the ADV7393
// line-fetch scheduler and its slot tracker.
//   LineActInterval_t  : [start, stop) active-line window
//   SchedState_t       : scheduler FSM states
//   frame_align_center : vertically centred window of a frame in a standard
//   frame_base         : byte base of the front or back frame buffer
//   line_offset        : byte offset of a line inside a frame buffer
// ---------------------------------------------------------------------------
package adv7393_fetch_sched_pkg;

  localparam int          LINES_CNT_W       = $clog2(625);
  localparam logic [31:0] LINE_STEP         = 32'h1000;
  localparam int          PIXELS_PER_SYMBOL = 4;

  // Black level (Y=0x10, Cb/Cr=0x80) the output stage drives for blank slots
  localparam logic [15:0] blank_val         = 16'h1080;

  typedef struct packed {
    logic [31:0] start;
    logic [31:0] stop;
  } LineActInterval_t;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    ISSUE,
    WAIT,
    BLANK
  } SchedState_t;

  // A frame taller than the standard is clipped to the standard's lines,
  // starting at the top; otherwise it is centred with the odd line at the bottom.
  function automatic LineActInterval_t frame_align_center(
    input logic [31:0] active_lines,
    input logic [31:0] lines
  );
    LineActInterval_t r;
    if (lines > active_lines) begin
      r.start = 32'd0;
      r.stop  = active_lines;
    end else begin
      r.start = (active_lines - lines) >> 1;
      r.stop  = r.start + lines;
    end
    return r;
  endfunction

  function automatic logic [31:0] frame_base(
    input logic [31:0] base,
    input logic        sel,
    input logic [31:0] lines,
    input logic [31:0] step
  );
    return sel ? (base + lines * step) : base;
  endfunction

  function automatic logic [31:0] line_offset(
    input logic [31:0] idx,
    input logic [31:0] start,
    input logic [31:0] step
  );
    return (idx - start) * step;
  endfunction

endpackage

// File: rtl/adv7393_fetch_sched_slot.sv
// ---------------------------------------------------------------------------
// adv7393_slot_tracker
// Ping-pong line-buffer slot bookkeeping: ready/blank flags per slot and the
// write-slot pointer.
//   aclk, aresetn  : clock, asynchronous active-low reset
//   set_i          : mark slot wr_slot as filled (and advance the pointer)
//   blank_i        : with set_i, the filled line is blank
//   wr_rst_i       : force the write pointer back to slot 0 (frame boundary)
//   release_i[1:0] : output stage frees a slot
//   slot_ready_o   : slot holds a line for the output stage
//   slot_blank_o   : slot's line is blank
//   wr_slot_o      : slot the next serviced line goes into
// ---------------------------------------------------------------------------
module adv7393_slot_tracker (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       set_i,
  input  logic       blank_i,
  input  logic       wr_rst_i,
  input  logic [1:0] release_i,
  output logic [1:0] slot_ready_o,
  output logic [1:0] slot_blank_o,
  output logic       wr_slot_o
);

  logic [1:0] ready_q, ready_d;
  logic [1:0] blank_q, blank_d;
  logic       wr_slot_q, wr_slot_d;

  always_comb begin
    ready_d   = ready_q;
    blank_d   = blank_q;
    wr_slot_d = wr_slot_q;
    for (int i = 0; i < 2; i++) begin
      // A fill landing in the same cycle as a release of that slot wins
      if (set_i && (wr_slot_q == 1'(i))) begin
        ready_d[i] = 1'b1;
        blank_d[i] = blank_i;
      end else if (release_i[i]) begin
        ready_d[i] = 1'b0;
        blank_d[i] = 1'b0;
      end
    end
    // The frame-boundary rewind overrides the post-fill toggle
    if (wr_rst_i) begin
      wr_slot_d = 1'b0;
    end else if (set_i) begin
      wr_slot_d = ~wr_slot_q;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ready_q   <= 2'b00;
      blank_q   <= 2'b00;
      wr_slot_q <= 1'b0;
    end else begin
      ready_q   <= ready_d;
      blank_q   <= blank_d;
      wr_slot_q <= wr_slot_d;
    end
  end

  assign slot_ready_o = ready_q;
  assign slot_blank_o = blank_q;
  assign wr_slot_o    = wr_slot_q;

endmodule

// File: rtl/adv7393_fetch_sched.sv
// ---------------------------------------------------------------------------
// adv7393_fetch_sched
// Line-fetch scheduler for the ADV7393 output path. Each line request either
// issues one AXI line-read command into a ping-pong slot or marks the slot
// blank when the line lies outside the vertically centred active window.
// The front/back frame-buffer select is latched only at frame start.
//
// Optional feature macro: ADV7393_SCHED_STATS_EN adds underrun_cnt
// (saturating) and lines_fetched (wrapping) counters, cleared on frame_start.
//
// Ports:
//   aclk, aresetn          : clock, asynchronous active-low reset
//   cfg_base/lines/line_len/active_lines : buffer and frame geometry
//   fb_sel_req, frame_start : buffer select request, frame boundary pulse
//   line_req, line_idx     : next-line request and its active-line index
//   cmd_valid/ready/addr/beats/slot : read command handshake to the reader
//   rd_done                : reader finished writing the slot
//   slot_ready, slot_blank, slot_release : slot status / free from output
//   fb_sel                 : frame buffer in use
//   underrun               : pulse when a line request is dropped
// ---------------------------------------------------------------------------
module adv7393_fetch_sched #(
  parameter int          LINES_CNT_W       = $clog2(625),
  parameter logic [31:0] LINE_STEP         = 32'h1000,
  parameter int          PIXELS_PER_SYMBOL = 4,
  parameter int          SLOTS             = 2
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [31:0]            cfg_base,
  input  logic [31:0]            cfg_lines,
  input  logic [31:0]            cfg_line_len,
  input  logic [31:0]            cfg_active_lines,
  input  logic                   fb_sel_req,
  input  logic                   frame_start,
  input  logic                   line_req,
  input  logic [LINES_CNT_W-1:0] line_idx,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [31:0]            cmd_addr,
  output logic [15:0]            cmd_beats,
  output logic                   cmd_slot,
  input  logic                   rd_done,
  output logic [1:0]             slot_ready,
  output logic [1:0]             slot_blank,
  input  logic [1:0]             slot_release,
  output logic                   fb_sel,
  output logic                   underrun
`ifdef ADV7393_SCHED_STATS_EN
  ,
  output logic [15:0]            underrun_cnt,
  output logic [15:0]            lines_fetched
`endif
);

  import adv7393_fetch_sched_pkg::*;

  // The slot tracker is a hard ping-pong pair
  if (SLOTS != 2) begin : g_slots_chk
    $error("adv7393_fetch_sched: SLOTS must be 2");
  end

  SchedState_t            state_q;
  logic [LINES_CNT_W-1:0] idx_q;
  logic                   cmd_valid_q;
  logic [31:0]            cmd_addr_q;
  logic [15:0]            cmd_beats_q;
  logic                   cmd_slot_q;
  logic                   fb_sel_q;
  logic                   underrun_q;
  logic                   wr_rst_pend_q;

  LineActInterval_t       win_c;
  logic [31:0]            idx_ext_c;
  logic                   in_win_c;
  logic [31:0]            addr_c;
  logic                   wr_slot;
  logic                   slot_busy_c;
  logic                   drop_c;
  logic                   to_idle_c;
  logic                   set_c;
  logic                   blank_c;
  logic                   wr_rst_c;

  function automatic logic [15:0] beats_of(input logic [31:0] len);
    return 16'(len / PIXELS_PER_SYMBOL);
  endfunction

  // Window and address are combinational off the captured index and
  // registered at the end of CALC; LINE_STEP is a power of two so the
  // multiplies collapse to shifts.
  always_comb begin
    win_c     = frame_align_center(cfg_active_lines, cfg_lines);
    idx_ext_c = 32'(idx_q);
    in_win_c  = (idx_ext_c >= win_c.start) && (idx_ext_c < win_c.stop);
    addr_c    = frame_base(cfg_base, fb_sel_q, cfg_lines, LINE_STEP)
              + line_offset(idx_ext_c, win_c.start, LINE_STEP);
  end

  // A frame_start seen in IDLE rewinds the pointer in the same edge, so the
  // occupancy check must look at slot 0 rather than the stale pointer.
  always_comb begin
    slot_busy_c = slot_ready[frame_start ? 1'b0 : wr_slot];
    drop_c      = line_req && ((state_q != IDLE) || slot_busy_c);
    to_idle_c   = ((state_q == WAIT) && rd_done) || (state_q == BLANK);
    // Blank fills are committed on entry to BLANK so they appear two
    // cycles after the request, like the command.
    set_c       = ((state_q == CALC) && !in_win_c) || ((state_q == WAIT) && rd_done);
    blank_c     = (state_q == CALC);
    wr_rst_c    = frame_start && (state_q == IDLE);
    if (to_idle_c && (wr_rst_pend_q || frame_start)) begin
      wr_rst_c = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_addr_q    <= 32'd0;
      cmd_beats_q   <= 16'd0;
      cmd_slot_q    <= 1'b0;
      fb_sel_q      <= 1'b0;
      underrun_q    <= 1'b0;
      wr_rst_pend_q <= 1'b0;
    end else begin
      underrun_q <= drop_c;

      if (frame_start) begin
        fb_sel_q <= fb_sel_req;
      end

      if (to_idle_c) begin
        wr_rst_pend_q <= 1'b0;
      end else if (frame_start && (state_q != IDLE)) begin
        wr_rst_pend_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (line_req && !slot_busy_c) begin
            idx_q   <= line_idx;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (in_win_c) begin
            cmd_addr_q  <= addr_c;
            cmd_beats_q <= beats_of(cfg_line_len);
            cmd_slot_q  <= wr_slot;
            cmd_valid_q <= 1'b1;
            state_q     <= ISSUE;
          end else begin
            state_q <= BLANK;
          end
        end
        ISSUE: begin
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (rd_done) begin
            state_q <= IDLE;
          end
        end
        BLANK: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef ADV7393_SCHED_STATS_EN
  logic [15:0] underrun_cnt_q;
  logic [15:0] lines_fetched_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      underrun_cnt_q  <= 16'd0;
      lines_fetched_q <= 16'd0;
    end else if (frame_start) begin
      underrun_cnt_q  <= 16'd0;
      lines_fetched_q <= 16'd0;
    end else begin
      if (drop_c && (underrun_cnt_q != 16'hFFFF)) begin
        underrun_cnt_q <= underrun_cnt_q + 16'd1;
      end
      if (cmd_valid_q && cmd_ready) begin
        lines_fetched_q <= lines_fetched_q + 16'd1;
      end
    end
  end

  assign underrun_cnt  = underrun_cnt_q;
  assign lines_fetched = lines_fetched_q;
`endif

  adv7393_slot_tracker u_slots (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .set_i        (set_c),
    .blank_i      (blank_c),
    .wr_rst_i     (wr_rst_c),
    .release_i    (slot_release),
    .slot_ready_o (slot_ready),
    .slot_blank_o (slot_blank),
    .wr_slot_o    (wr_slot)
  );

  assign cmd_valid = cmd_valid_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_beats = cmd_beats_q;
  assign cmd_slot  = cmd_slot_q;
  assign fb_sel    = fb_sel_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_adv7393_fetch_sched.sv
// ---------------------------------------------------------------------------
// tb_adv7393_fetch_sched
// Directed bench for adv7393_fetch_sched. Expected commands are queued when a
// line request is driven and compared when the command appears.
// ---------------------------------------------------------------------------
module tb_adv7393_fetch_sched;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] cfg_base, cfg_lines, cfg_line_len, cfg_active_lines;
  logic        fb_sel_req, frame_start, line_req;
  logic [9:0]  line_idx;
  logic        cmd_valid, cmd_ready, cmd_slot, rd_done, fb_sel, underrun;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_beats;
  logic [1:0]  slot_ready, slot_blank, slot_release;
`ifdef ADV7393_SCHED_STATS_EN
  logic [15:0] underrun_cnt, lines_fetched;
`endif

  adv7393_fetch_sched dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .cfg_base         (cfg_base),
    .cfg_lines        (cfg_lines),
    .cfg_line_len     (cfg_line_len),
    .cfg_active_lines (cfg_active_lines),
    .fb_sel_req       (fb_sel_req),
    .frame_start      (frame_start),
    .line_req         (line_req),
    .line_idx         (line_idx),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_addr         (cmd_addr),
    .cmd_beats        (cmd_beats),
    .cmd_slot         (cmd_slot),
    .rd_done          (rd_done),
    .slot_ready       (slot_ready),
    .slot_blank       (slot_blank),
    .slot_release     (slot_release),
    .fb_sel           (fb_sel),
    .underrun         (underrun)
`ifdef ADV7393_SCHED_STATS_EN
    ,
    .underrun_cnt     (underrun_cnt),
    .lines_fetched    (lines_fetched)
`endif
  );

  initial forever #5 aclk = ~aclk;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] beats;
    logic        slot;
  } cmd_t;

  cmd_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   n_fail = 0;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_fs(input logic sel);
    fb_sel_req  = sel;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic release_slots(input logic [1:0] m);
    slot_release = m;
    tick();
    slot_release = 2'b00;
  endtask

  // Request an in-window line, check 2-cycle latency, hold off cmd_ready for
  // 'stall' cycles, then accept.
  task automatic fetch(input logic [9:0] idx, input logic [31:0] addr, input logic slot,
                       input int stall, input logic with_fs, input logic sel);
    cmd_t e;
    e.addr  = addr;
    e.beats = 16'd160;
    e.slot  = slot;
    exp_q.push_back(e);
    line_req = 1'b1;
    line_idx = idx;
    if (with_fs) begin
      fb_sel_req  = sel;
      frame_start = 1'b1;
    end
    tick();
    line_req    = 1'b0;
    frame_start = 1'b0;
    chk("calc_no_vld", 32'(cmd_valid), 32'd0);
    tick();
    chk("cmd_latency", 32'(cmd_valid), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("cmd_addr", cmd_addr, e.addr);
      chk("cmd_beats", 32'(cmd_beats), 32'(e.beats));
      chk("cmd_slot", 32'(cmd_slot), 32'(e.slot));
    end
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_vld", 32'(cmd_valid), 32'd1);
      chk("stall_addr", cmd_addr, addr);
    end
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("accept_vld", 32'(cmd_valid), 32'd0);
  endtask

  task automatic done(input logic [1:0] exp_ready);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    chk("fill_ready", 32'(slot_ready), 32'(exp_ready));
    chk("fill_blank", 32'(slot_blank), 32'd0);
  endtask

  task automatic blank_line(input logic [9:0] idx, input logic [1:0] er, input logic [1:0] eb);
    line_req = 1'b1;
    line_idx = idx;
    tick();
    line_req = 1'b0;
    chk("blank_calc_vld", 32'(cmd_valid), 32'd0);
    tick();
    chk("blank_ready", 32'(slot_ready), 32'(er));
    chk("blank_flag", 32'(slot_blank), 32'(eb));
    chk("blank_no_vld", 32'(cmd_valid), 32'd0);
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vld"}, 32'(cmd_valid), 32'd0);
    chk({tag, "_addr"}, cmd_addr, 32'd0);
    chk({tag, "_beats"}, 32'(cmd_beats), 32'd0);
    chk({tag, "_slot"}, 32'(cmd_slot), 32'd0);
    chk({tag, "_ready"}, 32'(slot_ready), 32'd0);
    chk({tag, "_blank"}, 32'(slot_blank), 32'd0);
    chk({tag, "_fbsel"}, 32'(fb_sel), 32'd0);
    chk({tag, "_underrun"}, 32'(underrun), 32'd0);
  endtask

  initial begin
    aresetn          = 1'b0;
    cfg_base         = 32'h10000;
    cfg_lines        = 32'd480;
    cfg_line_len     = 32'd640;
    cfg_active_lines = 32'd576;
    fb_sel_req       = 1'b0;
    frame_start      = 1'b0;
    line_req         = 1'b0;
    line_idx         = 10'd0;
    cmd_ready        = 1'b0;
    rd_done          = 1'b0;
    slot_release     = 2'b00;

    repeat (3) tick();
    chk_all_zero("rst");
    aresetn = 1'b1;
    tick();

    // Centred window: first active line, then the line just above it
    pulse_fs(1'b0);
    fetch(10'd48, 32'h10000, 1'b0, 0, 1'b0, 1'b0);
    done(2'b01);
    release_slots(2'b01);
    chk("rel0", 32'(slot_ready), 32'd0);
    blank_line(10'd47, 2'b10, 2'b10);
    release_slots(2'b10);
    chk("rel1_ready", 32'(slot_ready), 32'd0);
    chk("rel1_blank", 32'(slot_blank), 32'd0);

    // Back buffer with 10 cycles of backpressure
    pulse_fs(1'b1);
    chk("fb_back", 32'(fb_sel), 32'd1);
    fetch(10'd49, 32'h1F1000, 1'b0, 10, 1'b0, 1'b0);
    // A request while waiting for the reader is dropped
    line_req = 1'b1;
    line_idx = 10'd50;
    tick();
    line_req = 1'b0;
    chk("busy_underrun", 32'(underrun), 32'd1);
    tick();
    chk("busy_underrun_clr", 32'(underrun), 32'd0);
    // Select change without frame_start is not applied
    fb_sel_req = 1'b0;
    repeat (2) tick();
    chk("fb_held", 32'(fb_sel), 32'd1);
    done(2'b01);
    release_slots(2'b01);

    // frame_start with line_req: new buffer and slot 0 apply to that line
    fetch(10'd48, 32'h10000, 1'b0, 0, 1'b1, 1'b0);
    chk("fb_front", 32'(fb_sel), 32'd0);
    done(2'b01);
    release_slots(2'b01);

    // Ping-pong full: two fills, then the third request underruns
    fetch(10'd100, 32'h44000, 1'b1, 0, 1'b0, 1'b0);
    done(2'b10);
    fetch(10'd101, 32'h45000, 1'b0, 0, 1'b0, 1'b0);
    done(2'b11);
    line_req = 1'b1;
    line_idx = 10'd102;
    tick();
    line_req = 1'b0;
    chk("full_underrun", 32'(underrun), 32'd1);
    tick();
    chk("full_underrun_clr", 32'(underrun), 32'd0);
    chk("full_no_vld", 32'(cmd_valid), 32'd0);
`ifdef ADV7393_SCHED_STATS_EN
    chk("underrun_cnt", 32'(underrun_cnt), 32'd1);
    chk("lines_fetched", 32'(lines_fetched), 32'd3);
`endif

    // Reset while waiting for the reader
    pulse_fs(1'b1);
    chk("fb_back2", 32'(fb_sel), 32'd1);
    release_slots(2'b01);
    fetch(10'd60, 32'h1FC000, 1'b0, 0, 1'b0, 1'b0);
    aresetn = 1'b0;
    #2;
    chk_all_zero("midrst");
`ifdef ADV7393_SCHED_STATS_EN
    chk("midrst_ucnt", 32'(underrun_cnt), 32'd0);
`endif
    tick();
    aresetn = 1'b1;
    tick();
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    chk("stray_rd_done", 32'(slot_ready), 32'd0);
    fetch(10'd48, 32'h10000, 1'b0, 0, 1'b0, 1'b0);
    done(2'b01);

    // Frame taller than the standard: window becomes [0, 576)
    cfg_lines = 32'd600;
    blank_line(10'd576, 2'b11, 2'b10);
    release_slots(2'b11);
    chk("clip_rel", 32'(slot_ready), 32'd0);
    fetch(10'd575, 32'h24F000, 1'b0, 0, 1'b0, 1'b0);
    done(2'b01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
